// File: rtl/pipe_stage_pkg.sv
// Shared pipeline payload layout and helper types for the in-order core stage registers.
// Callers pack/unpack stage payloads using these widths and offsets.
package pipe_stage_pkg;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    // IF->ID: {pred_taken, fetch_fault, instr, pc}
    localparam int unsigned IF_ID_PC_OFF    = 0;
    localparam int unsigned IF_ID_INSTR_OFF = IF_ID_PC_OFF + PC_WIDTH;
    localparam int unsigned IF_ID_FAULT_OFF = IF_ID_INSTR_OFF + INSTR_WIDTH;
    localparam int unsigned IF_ID_PRED_OFF  = IF_ID_FAULT_OFF + 1;
    localparam int unsigned PAYLOAD_IF_ID_W = IF_ID_PRED_OFF + 1;

    // ID->EX: {pred_taken, illegal, rs2_val, rs1_val, instr, pc}
    localparam int unsigned ID_EX_PC_OFF    = 0;
    localparam int unsigned ID_EX_INSTR_OFF = ID_EX_PC_OFF + PC_WIDTH;
    localparam int unsigned ID_EX_RS1_OFF   = ID_EX_INSTR_OFF + INSTR_WIDTH;
    localparam int unsigned ID_EX_RS2_OFF   = ID_EX_RS1_OFF + 32;
    localparam int unsigned ID_EX_ILL_OFF   = ID_EX_RS2_OFF + 32;
    localparam int unsigned ID_EX_PRED_OFF  = ID_EX_ILL_OFF + 1;
    localparam int unsigned PAYLOAD_ID_EX_W = ID_EX_PRED_OFF + 1;

    // EX->MEM: {mem_we, mem_re, store_val, alu_res, pc}
    localparam int unsigned EX_MEM_PC_OFF    = 0;
    localparam int unsigned EX_MEM_ALU_OFF   = EX_MEM_PC_OFF + PC_WIDTH;
    localparam int unsigned EX_MEM_STV_OFF   = EX_MEM_ALU_OFF + 32;
    localparam int unsigned EX_MEM_RE_OFF    = EX_MEM_STV_OFF + 32;
    localparam int unsigned EX_MEM_WE_OFF    = EX_MEM_RE_OFF + 1;
    localparam int unsigned PAYLOAD_EX_MEM_W = EX_MEM_WE_OFF + 1;

    typedef struct packed {
        logic                   pred_taken;
        logic                   fetch_fault;
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
    } if_id_payload_t;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for perf statistics; cleared only by synchronous reset.
module pipe_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] out
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage register with flush, stall and a held-cycle perf counter.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered up_ready_o.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              dn_ready_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  held_cnt_o
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              dn_fire, up_fire, held_inc;
    occ_t              occ;

    assign dn_valid_o = main_valid_q & ~stall_i & ~flush_i;
    assign dn_data_o  = dn_valid_o ? main_data_q : '0;
    assign dn_fire    = dn_valid_o & dn_ready_i;
    assign up_fire    = up_valid_i & up_ready_o;
    assign held_inc   = main_valid_q & ~dn_fire & ~flush_i;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Registered ready: skid absorbs the beat that arrives while downstream backs up.
    assign up_ready_o = ~skid_valid_q & ~stall_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (dn_fire) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (up_fire) begin
                main_data_d  = up_data_i;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (up_fire) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = up_data_i;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = up_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

    assign occ = occ_t'({1'b0, main_valid_q}) + occ_t'({1'b0, skid_valid_q});
`else
    assign up_ready_o = (~main_valid_q | dn_ready_i) & ~stall_i & ~flush_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
        end else if (up_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = up_data_i;
        end else if (dn_fire) begin
            main_valid_d = 1'b0;
        end
    end

    assign occ = {1'b0, main_valid_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
    end

    assign occ_o = occ;

    pipe_sat_cnt #(
        .W (CNT_W)
    ) u_held_cnt (
        .clk (clk),
        .rst (rst),
        .inc (held_inc),
        .out (held_cnt_o)
    );

endmodule
